arb_mux: RTL and testbench



---
 rtl/arb_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/arb_mux.sv | 125 ++++++++++++
 tb/tb_arb_mux.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared mode constants and index-width helper for arb_mux
package arb_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_ARB = 1'b1;

    // Never returns 0, so a channel index always has at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational first-valid search starting at ptr, wrapping modulo NCH
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int SW  = idx_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    output logic [SW-1:0]  grant,
    output logic           grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!grant_valid && req[idx]) begin
                grant       = SW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel registered mux with select or arbitrated grant; ARB_MUX_RR_EN enables round-robin
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int SW  = idx_width(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_err
);

    // Inputs padded to a power of two so any SW-bit index stays in range.
    localparam int NP = 1 << SW;

    logic [NP-1:0]   valid_pad;
    logic [NP*W-1:0] data_pad;
    logic            sel_oob;
    logic [SW-1:0]   arb_ptr;
    logic [SW-1:0]   arb_grant;
    logic            arb_gv;
    logic [SW-1:0]   grant;
    logic            grant_valid;
    logic            load;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SW-1:0]   out_ch_q,    out_ch_d;
    logic            sel_err_q,   sel_err_d;

    assign valid_pad = NP'(in_valid);
    assign data_pad  = (NP*W)'(in_data);
    assign sel_oob   = (mode == MODE_SEL) && (int'(sel) >= NCH);

`ifdef ARB_MUX_RR_EN
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    assign arb_ptr = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load && mode == MODE_ARB)
            rr_ptr_d = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    assign arb_ptr = '0;
`endif

    rr_arbiter #(.NCH(NCH), .SW(SW)) u_arb (
        .req         (in_valid),
        .ptr         (arb_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_gv)
    );

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (mode == MODE_ARB) begin
            grant       = arb_grant;
            grant_valid = arb_gv;
        end else if (!sel_oob) begin
            grant       = sel;
            grant_valid = valid_pad[sel];
        end
    end

    // The register may reload on the same edge it drains.
    assign load = (!out_valid_q || out_ready) && grant_valid && !rst;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++)
            in_ready[i] = load && (grant == SW'(i));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        sel_err_d   = sel_err_q | sel_oob;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = data_pad[grant*W +: W];
            out_ch_d    = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - directed self-checking bench for arb_mux (4-channel and 3-channel instances)
module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst;

    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;
    logic        sel_err3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arb_mux #(.NCH(4), .W(8)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    arb_mux #(.NCH(3), .W(8)) u_dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3), .sel_err(sel_err3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words();
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
    endtask

    initial begin
        rst        = 1'b1;
        mode       = 1'b1;
        sel        = 2'd0;
        in_valid   = 4'b1111;
        out_ready  = 1'b1;
        load_words();
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_data3   = 24'h0;
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;

        tick();
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_out_ch", 32'(out_ch), 32'h0);
        check_eq("rst_sel_err", 32'(sel_err), 32'h0);
        rst      = 1'b0;
        in_valid = 4'b0000;
        tick();

        // explicit select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data[2*8 +: 8] = 8'hA5;
        #1;
        check_eq("sel_in_ready", 32'(in_ready), 32'h4);
        tick();
        check_eq("sel_out_valid", 32'(out_valid), 32'h1);
        check_eq("sel_out_data", 32'(out_data), 32'hA5);
        check_eq("sel_out_ch", 32'(out_ch), 32'h2);
        in_valid = 4'b0000;
        tick();
        check_eq("sel_drain", 32'(out_valid), 32'h0);

        load_words();
        mode = 1'b1;
`ifdef ARB_MUX_RR_EN
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check_eq("rr_out_ch", 32'(out_ch), 32'(k % 4));
            check_eq("rr_out_data", 32'(out_data), 32'h10 + 32'(k % 4));
        end
`else
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("fp_in_ready", 32'(in_ready), 32'h2);
            tick();
            check_eq("fp_out_ch", 32'(out_ch), 32'h1);
            check_eq("fp_out_data", 32'(out_data), 32'h11);
        end
`endif
        in_valid = 4'b0000;
        tick();
        check_eq("arb_drain", 32'(out_valid), 32'h0);

        // back-pressure, then load-while-drain
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b0010;
        in_data[1*8 +: 8] = 8'h5C;
        tick();
        check_eq("bp_first", 32'(out_data), 32'h5C);
        out_ready = 1'b0;
        in_data[1*8 +: 8] = 8'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            check_eq("bp_hold_data", 32'(out_data), 32'h5C);
            check_eq("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(in_ready), 32'h2);
        tick();
        check_eq("bp_reload_data", 32'(out_data), 32'h77);
        check_eq("bp_reload_valid", 32'(out_valid), 32'h1);
        in_valid = 4'b0000;
        tick();
        check_eq("bp_drain", 32'(out_valid), 32'h0);
        check_eq("sel_err_clean", 32'(sel_err), 32'h0);

        // reset while holding a word; arbitration restarts at channel 0
        load_words();
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        tick();
        check_eq("mid_loaded", 32'(out_valid), 32'h1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
        check_eq("mid_rst_data", 32'(out_data), 32'h0);
        check_eq("mid_rst_ch", 32'(out_ch), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("post_rst_ch", 32'(out_ch), 32'h0);
        check_eq("post_rst_data", 32'(out_data), 32'h10);
        in_valid = 4'b0000;
        tick();

        // 3-channel instance: out-of-range select
        in_data3  = 24'h2B1A3C;
        in_valid3 = 3'b111;
        sel3      = 2'd3;
        #1;
        check_eq("oob_in_ready", 32'(in_ready3), 32'h0);
        tick();
        check_eq("oob_out_valid", 32'(out_valid3), 32'h0);
        check_eq("oob_sel_err", 32'(sel_err3), 32'h1);
        sel3 = 2'd0;
        tick();
        tick();
        check_eq("oob_sticky", 32'(sel_err3), 32'h1);
        check_eq("oob_then_ch", 32'(out_ch3), 32'h0);
        check_eq("oob_then_data", 32'(out_data3), 32'h3C);
        sel3 = 2'd2;
        tick();
        check_eq("nch3_ch2_data", 32'(out_data3), 32'h2B);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid3 = 3'b000;
        tick();
        check_eq("oob_cleared", 32'(sel_err3), 32'h0);
        check_eq("nch3_idle", 32'(out_valid3), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
